// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared CPU bus defaults, responder state encoding and helpers
package data_mem_responder_pkg;
   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 4;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;
   function automatic logic misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: CPU load/store bus between requester (master) and memory (slave)
interface data_mem_responder_if import data_mem_responder_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              req;
   logic              we;
   logic [ADDR_W+1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              err;
   logic              busy;
   modport master (output req, we, addr, wdata, input rdata, ack, err, busy);
   modport slave  (input req, we, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/data_mem_responder_array.sv
// data_mem_responder_array: word storage with synchronous write, asynchronous read, no reset
module data_mem_responder_array import data_mem_responder_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   // contents survive reset; only an explicit write changes a word
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: slow-memory model answering req/ack bus requests after WAIT_CYCLES wait states
module data_mem_responder import data_mem_responder_pkg::*; #(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_responder_if.slave  bus
);
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d, mis_q, mis_d, err_q, err_d;
   logic [ADDR_W-1:0] word_q, word_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, mem_rdata;
   logic              go_ack, mem_we, cur_we, cur_mis;
   logic [ADDR_W-1:0] cur_word;
   logic [DATA_W-1:0] cur_wdata;
   // with zero wait states the access happens on the accepting edge, so use the live bus
   always_comb begin
      cur_we    = (state_q == S_IDLE) ? bus.we : we_q;
      cur_mis   = (state_q == S_IDLE) ? misaligned(bus.addr[1:0]) : mis_q;
      cur_word  = (state_q == S_IDLE) ? bus.addr[ADDR_W+1:2] : word_q;
      cur_wdata = (state_q == S_IDLE) ? bus.wdata : wdata_q;
   end
   // next state, wait counter, operand capture and access results
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      mis_d   = mis_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      go_ack  = 1'b0;
      case (state_q)
         S_IDLE: if (bus.req) begin
            we_d    = bus.we;
            mis_d   = misaligned(bus.addr[1:0]);
            word_d  = bus.addr[ADDR_W+1:2];
            wdata_d = bus.wdata;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
            go_ack  = (WAIT_CYCLES == 0);
         end
         S_WAIT: if (!bus.req) state_d = S_IDLE;
         else begin
            cnt_d   = cnt_q - 1'b1;
            go_ack  = (cnt_q == CNT_W'(1));
            state_d = go_ack ? S_ACK : S_WAIT;
         end
         S_ACK: if (!bus.req) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
      if (go_ack) begin
         err_d   = cur_mis;
         rdata_d = cur_mis ? '0 : (cur_we ? rdata_q : mem_rdata);
      end
   end
   // a reset on the completing edge must also cancel the write
   assign mem_we = go_ack & ~cur_mis & cur_we & rst;
   data_mem_responder_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (cur_word),
      .wdata_i (cur_wdata),
      .raddr_i (cur_word),
      .rdata_o (mem_rdata)
   );
   // state and operand registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         mis_q   <= 1'b0;
         word_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         mis_q   <= mis_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end
   assign bus.ack   = (state_q == S_ACK);
   assign bus.busy  = (state_q != S_IDLE);
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of the wait-state memory responder (2 and 0 wait states)
module tb_data_mem_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sel = 1'b0;
   logic        req_t = 1'b0, we_t = 1'b0;
   logic [7:0]  addr_t = '0;
   logic [31:0] wdata_t = '0;
   logic        ack_s, err_s, busy_s;
   logic [31:0] rdata_s;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   data_mem_responder_if #(.ADDR_W(6), .DATA_W(32)) bus2 ();
   data_mem_responder_if #(.ADDR_W(6), .DATA_W(32)) bus0 ();

   assign bus2.req   = req_t & ~sel;
   assign bus2.we    = we_t;
   assign bus2.addr  = addr_t;
   assign bus2.wdata = wdata_t;
   assign bus0.req   = req_t & sel;
   assign bus0.we    = we_t;
   assign bus0.addr  = addr_t;
   assign bus0.wdata = wdata_t;
   assign ack_s   = sel ? bus0.ack   : bus2.ack;
   assign err_s   = sel ? bus0.err   : bus2.err;
   assign busy_s  = sel ? bus0.busy  : bus2.busy;
   assign rdata_s = sel ? bus0.rdata : bus2.rdata;

   data_mem_responder #(.ADDR_W(6), .DATA_W(32), .WAIT_CYCLES(2)) dut2 (
      .clk (clk), .rst (rst), .bus (bus2.slave));
   data_mem_responder #(.ADDR_W(6), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
      .clk (clk), .rst (rst), .bus (bus0.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one full 4-phase transaction starting at a negedge; ends at a negedge with req low and ack gone
   task automatic txn(input string tag, input logic w, input logic [11:0] a, input logic [31:0] d,
                      input int hold, input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
      int  lat;
      logic busy_ok;
      req_t = 1'b1; we_t = w; addr_t = a[7:0]; wdata_t = d;
      lat = 0; busy_ok = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         busy_ok &= busy_s;
      end while (!ack_s && lat < 20);
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
      chk({tag, " err"}, {31'd0, err_s}, {31'd0, exp_err});
      if (!w || exp_err) chk({tag, " rdata"}, rdata_s, exp_rd);
      for (int i = 0; i < hold; i++) begin
         chk({tag, " ack held"}, {31'd0, ack_s}, 32'd1);
         wdata_t = ~d;
         @(negedge clk);
      end
      req_t = 1'b0;
      @(negedge clk);
      chk({tag, " ack released"}, {31'd0, ack_s}, 32'd0);
      chk({tag, " err released"}, {31'd0, err_s}, 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset ack", {31'd0, ack_s}, 32'd0);
      chk("reset busy", {31'd0, busy_s}, 32'd0);
      chk("reset err", {31'd0, err_s}, 32'd0);
      chk("reset rdata", rdata_s, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      // basic write then read
      txn("t1 wr", 1'b1, 12'h008, 32'hDEADBEEF, 0, 3, 32'h0, 1'b0);
      txn("t1 rd", 1'b0, 12'h008, 32'h0, 0, 3, 32'hDEADBEEF, 1'b0);
      // misaligned write leaves the word untouched
      txn("t2 pre", 1'b1, 12'h004, 32'h0BADF00D, 0, 3, 32'h0, 1'b0);
      txn("t2 mis", 1'b1, 12'h005, 32'h12345678, 0, 3, 32'h0, 1'b1);
      txn("t2 rd", 1'b0, 12'h004, 32'h0, 0, 3, 32'h0BADF00D, 1'b0);
      // abort during WAIT
      txn("t3 pre", 1'b1, 12'h010, 32'h11111111, 0, 3, 32'h0, 1'b0);
      req_t = 1'b1; we_t = 1'b1; addr_t = 8'h10; wdata_t = 32'hAAAA5555;
      @(negedge clk);
      chk("t3 busy in wait", {31'd0, busy_s}, 32'd1);
      req_t = 1'b0;
      @(negedge clk);
      chk("t3 abort busy", {31'd0, busy_s}, 32'd0);
      chk("t3 abort ack", {31'd0, ack_s}, 32'd0);
      txn("t3 rd", 1'b0, 12'h010, 32'h0, 0, 3, 32'h11111111, 1'b0);
      // reset on the edge that would complete the write
      txn("t4 pre", 1'b1, 12'h020, 32'h22222222, 0, 3, 32'h0, 1'b0);
      req_t = 1'b1; we_t = 1'b1; addr_t = 8'h20; wdata_t = 32'h33333333;
      repeat (2) @(negedge clk);
      chk("t4 busy in wait", {31'd0, busy_s}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("t4 rst ack", {31'd0, ack_s}, 32'd0);
      chk("t4 rst busy", {31'd0, busy_s}, 32'd0);
      chk("t4 rst rdata", rdata_s, 32'd0);
      rst = 1'b1; req_t = 1'b0;
      @(negedge clk);
      txn("t4 rd", 1'b0, 12'h020, 32'h0, 0, 3, 32'h22222222, 1'b0);
      // zero wait states and address wrap
      sel = 1'b1;
      @(negedge clk);
      txn("t5 wr fc", 1'b1, 12'h0FC, 32'h1, 0, 1, 32'h0, 1'b0);
      txn("t5 wr 00", 1'b1, 12'h000, 32'h2, 0, 1, 32'h0, 1'b0);
      txn("t5 wr 100", 1'b1, 12'h100, 32'h3, 0, 1, 32'h0, 1'b0);
      txn("t5 rd fc", 1'b0, 12'h0FC, 32'h0, 0, 1, 32'h1, 1'b0);
      txn("t5 rd 00", 1'b0, 12'h000, 32'h0, 0, 1, 32'h3, 1'b0);
      sel = 1'b0;
      @(negedge clk);
      // long-held req: one access only, then back-to-back transaction
      txn("t6 wr", 1'b1, 12'h030, 32'h44444444, 5, 3, 32'h0, 1'b0);
      txn("t6 rd", 1'b0, 12'h030, 32'h0, 0, 3, 32'h44444444, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
